// File: rtl/pingpong_blk_select.sv
// Parametrised ping/pong sub-block selector: two pipelined N-to-1 mux paths
// with per-path take gating, hold registers and a single arbitrated output word.
module pingpong_blk_select #(
    parameter int DATA_W     = 32,
    parameter int NUM_IN     = 16,
    parameter int SEL_W      = 4,
    parameter int MUX_STAGES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     flush,
    input  logic                     pingpong,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] a_data,
    input  logic                     a_pang_en,
    input  logic [SEL_W-1:0]         a_pang_start,
    input  logic [SEL_W-1:0]         a_pang_end,
    input  logic [NUM_IN*DATA_W-1:0] b_data,
    input  logic                     b_pang_en,
    input  logic [SEL_W-1:0]         b_pang_start,
    input  logic [SEL_W-1:0]         b_pang_end,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_src
);

    // One extra bit so the range test stays meaningful when NUM_IN == 2**SEL_W.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              take_a;
        logic              take_b;
        logic              pp;
    } stage_t;

    function automatic logic in_window(input logic [SEL_W-1:0] s,
                                       input logic [SEL_W-1:0] st,
                                       input logic [SEL_W-1:0] en);
        if (st <= en) return (s >= st) && (s <= en);
        else          return (s >= st) || (s <= en);
    endfunction

    logic              sel_ok;
    logic              take_a_in;
    logic              take_b_in;
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;

    stage_t            pipe_q [MUX_STAGES];
    stage_t            pipe_d [MUX_STAGES];
    stage_t            last;

    logic              take_a_c_q, take_a_c_d;
    logic              take_b_c_q, take_b_c_d;
    logic              pp_c_q,     pp_c_d;
    logic [DATA_W-1:0] hold_a_q,   hold_a_d;
    logic [DATA_W-1:0] hold_b_q,   hold_b_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_src_q,  out_src_d;

    // Input decode: range check, window tests, take rule and way select.
    always_comb begin
        sel_ok    = {1'b0, sel} < NUM_IN_W;
        take_a_in = in_valid && sel_ok &&
                    (pingpong || (a_pang_en && in_window(sel, a_pang_start, a_pang_end)));
        take_b_in = in_valid && sel_ok &&
                    (!pingpong || (b_pang_en && in_window(sel, b_pang_start, b_pang_end)));
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_a = a_data[i*DATA_W +: DATA_W];
                mux_b = b_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pipe_d[0] = '{a: mux_a, b: mux_b, take_a: take_a_in, take_b: take_b_in, pp: pingpong};
        for (int s = 1; s < MUX_STAGES; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        // Flush drops the beat at the input as well as every beat in flight.
        if (flush) begin
            for (int s = 0; s < MUX_STAGES; s++) begin
                pipe_d[s].take_a = 1'b0;
                pipe_d[s].take_b = 1'b0;
            end
        end
    end

    always_comb begin
        last        = pipe_q[MUX_STAGES-1];
        take_a_c_d  = last.take_a && !flush;
        take_b_c_d  = last.take_b && !flush;
        pp_c_d      = last.pp;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = 1'b0;
        if (flush) begin
            hold_a_d = '0;
            hold_b_d = '0;
        end else begin
            if (last.take_a) hold_a_d = last.a;
            if (last.take_b) hold_b_d = last.b;
            // The delayed turn flag alone arbitrates; an off-turn take only refreshes its hold.
            if (pp_c_q && take_a_c_q) begin
                out_data_d  = hold_a_q;
                out_src_d   = 1'b0;
                out_valid_d = 1'b1;
            end else if (!pp_c_q && take_b_c_q) begin
                out_data_d  = hold_b_q;
                out_src_d   = 1'b1;
                out_valid_d = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pipeline array is reset too, since every stage must read 0 after reset.
            for (int s = 0; s < MUX_STAGES; s++) begin
                pipe_q[s] <= '0;
            end
            take_a_c_q  <= 1'b0;
            take_b_c_q  <= 1'b0;
            pp_c_q      <= 1'b0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            for (int s = 0; s < MUX_STAGES; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
            take_a_c_q  <= take_a_c_d;
            take_b_c_q  <= take_b_c_d;
            pp_c_q      <= pp_c_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_pingpong_blk_select.sv
// Bench for pingpong_blk_select: a 16-way and a 12-way instance share stimulus;
// a per-beat expectation queue is checked when each beat leaves the pipeline.
module tb_pingpong_blk_select;

    localparam int DW  = 32;
    localparam int LAT = 6;

    typedef struct packed {
        logic [1:0]         valid;
        logic [1:0]         src;
        logic [1:0][DW-1:0] data;
    } rec_t;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           flush;
    logic           pingpong;
    logic [3:0]     sel;
    logic [16*DW-1:0] a_data;
    logic [16*DW-1:0] b_data;
    logic           a_pang_en, b_pang_en;
    logic [3:0]     a_pang_start, a_pang_end, b_pang_start, b_pang_end;
    logic [DW-1:0]  out_data0, out_data1;
    logic           out_valid0, out_valid1;
    logic           out_src0, out_src1;

    rec_t           sb[$];
    logic [DW-1:0]  exp_data [2];
    logic           exp_src  [2];
    int             n_vec;
    int             n_bad;

    pingpong_blk_select #(.DATA_W(DW), .NUM_IN(16), .SEL_W(4), .MUX_STAGES(4)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .pingpong(pingpong),
        .sel(sel), .a_data(a_data), .a_pang_en(a_pang_en), .a_pang_start(a_pang_start),
        .a_pang_end(a_pang_end), .b_data(b_data), .b_pang_en(b_pang_en),
        .b_pang_start(b_pang_start), .b_pang_end(b_pang_end),
        .out_data(out_data0), .out_valid(out_valid0), .out_src(out_src0)
    );

    pingpong_blk_select #(.DATA_W(DW), .NUM_IN(12), .SEL_W(4), .MUX_STAGES(4)) u_dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .pingpong(pingpong),
        .sel(sel), .a_data(a_data[12*DW-1:0]), .a_pang_en(a_pang_en),
        .a_pang_start(a_pang_start), .a_pang_end(a_pang_end), .b_data(b_data[12*DW-1:0]),
        .b_pang_en(b_pang_en), .b_pang_start(b_pang_start), .b_pang_end(b_pang_end),
        .out_data(out_data1), .out_valid(out_valid1), .out_src(out_src1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic in_win(input logic [3:0] s, input logic [3:0] st, input logic [3:0] en);
        if (st <= en) return (s >= st) && (s <= en);
        else          return (s >= st) || (s <= en);
    endfunction

    function automatic logic [DW-1:0] way(input logic [16*DW-1:0] d, input logic [3:0] s);
        return d[int'(s)*DW +: DW];
    endfunction

    task automatic reset_sb();
        rec_t idle;
        idle = '0;
        sb.delete();
        for (int i = 0; i < LAT-1; i++) sb.push_back(idle);
        for (int d = 0; d < 2; d++) begin
            exp_data[d] = '0;
            exp_src[d]  = 1'b0;
        end
    endtask

    // Drive one beat at the current falling edge, record its expected effect,
    // advance one cycle and check the beat that is due at the outputs.
    task automatic tick(input logic v, input logic pp, input logic [3:0] s, input logic fl);
        rec_t r;
        rec_t t;
        logic act_v, act_s;
        logic [DW-1:0] act_d;
        in_valid = v;
        pingpong = pp;
        sel      = s;
        flush    = fl;
        if (fl) begin
            for (int i = 0; i < sb.size(); i++) begin
                t = sb[i];
                t.valid = '0;
                sb[i] = t;
            end
        end
        r = '0;
        for (int d = 0; d < 2; d++) begin
            logic ok, ta, tb;
            ok = int'(s) < ((d == 0) ? 16 : 12);
            ta = v && ok && !fl && (pp  || (a_pang_en && in_win(s, a_pang_start, a_pang_end)));
            tb = v && ok && !fl && (!pp || (b_pang_en && in_win(s, b_pang_start, b_pang_end)));
            if (pp && ta) begin
                r.valid[d] = 1'b1; r.src[d] = 1'b0; r.data[d] = way(a_data, s);
            end else if (!pp && tb) begin
                r.valid[d] = 1'b1; r.src[d] = 1'b1; r.data[d] = way(b_data, s);
            end
        end
        sb.push_back(r);
        @(negedge clk);
        r = sb.pop_front();
        for (int d = 0; d < 2; d++) begin
            act_v = (d == 0) ? out_valid0 : out_valid1;
            act_d = (d == 0) ? out_data0  : out_data1;
            act_s = (d == 0) ? out_src0   : out_src1;
            if (r.valid[d]) begin
                exp_data[d] = r.data[d];
                exp_src[d]  = r.src[d];
            end
            n_vec++;
            if (act_v !== r.valid[d]) begin
                n_bad++;
                $display("FAIL out_valid dut%0d t=%0t got %b want %b", d, $time, act_v, r.valid[d]);
            end
            n_vec++;
            if (act_d !== exp_data[d]) begin
                n_bad++;
                $display("FAIL out_data dut%0d t=%0t got %h want %h", d, $time, act_d, exp_data[d]);
            end
            n_vec++;
            if (act_s !== exp_src[d]) begin
                n_bad++;
                $display("FAIL out_src dut%0d t=%0t got %b want %b", d, $time, act_s, exp_src[d]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; flush = 1'b0; pingpong = 1'b0; sel = '0;
        a_data = '0; b_data = '0;
        a_pang_en = 1'b0; a_pang_start = '0; a_pang_end = '0;
        b_pang_en = 1'b0; b_pang_start = '0; b_pang_end = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_data0, out_valid0, out_src0, out_data1, out_valid1, out_src1} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got %h/%b/%b %h/%b/%b want all 0",
                     out_data0, out_valid0, out_src0, out_data1, out_valid1, out_src1);
        end
        reset = 1'b0;
        reset_sb();
    endtask

    task automatic test_first_beat();
        a_data[5*DW +: DW] = 32'hA5A5_0005;
        tick(1'b1, 1'b1, 4'd5, 1'b0);
        idle(7);
        n_vec++;
        if (out_data0 !== 32'hA5A5_0005 || out_valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL first_beat_held got %h/%b want a5a50005/0", out_data0, out_valid0);
        end
    endtask

    task automatic test_b_turn();
        b_pang_en = 1'b0;
        b_data[3*DW +: DW] = 32'h0000_00B3;
        tick(1'b1, 1'b0, 4'd3, 1'b0);
        a_pang_en = 1'b0;
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 4'd3, 1'b0);
        n_vec++;
        if (out_data0 !== 32'h0000_00B3 || out_src0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL b_turn_held got %h/%b/%b want b3/1/0", out_data0, out_src0, out_valid0);
        end
    endtask

    task automatic test_wrap_pang();
        a_pang_en = 1'b1; a_pang_start = 4'd14; a_pang_end = 4'd1;
        a_data[15*DW +: DW] = 32'h0000_0015;
        b_data[15*DW +: DW] = 32'hB000_0015;
        tick(1'b1, 1'b0, 4'd15, 1'b0);
        idle(4);
        n_vec++;
        if (u_dut16.hold_a_q !== 32'h0000_0015) begin
            n_bad++;
            $display("FAIL pang_capture got %h want 00000015", u_dut16.hold_a_q);
        end
        a_data[7*DW +: DW] = 32'h0000_0077;
        b_data[7*DW +: DW] = 32'hB000_0007;
        tick(1'b1, 1'b0, 4'd7, 1'b0);
        idle(4);
        n_vec++;
        if (u_dut16.hold_a_q !== 32'h0000_0015) begin
            n_bad++;
            $display("FAIL pang_outside got %h want 00000015", u_dut16.hold_a_q);
        end
        a_data[0 +: DW] = 32'h0000_00F0;
        tick(1'b1, 1'b1, 4'd0, 1'b0);
        idle(7);
        n_vec++;
        if (out_data0 !== 32'h0000_00F0 || out_src0 !== 1'b0) begin
            n_bad++;
            $display("FAIL pang_surface got %h/%b want f0/0", out_data0, out_src0);
        end
        a_pang_en = 1'b0;
    endtask

    task automatic test_out_of_range();
        a_data[13*DW +: DW] = 32'hDEAD_000D;
        a_data[11*DW +: DW] = 32'hCAFE_000B;
        tick(1'b1, 1'b1, 4'd13, 1'b0);
        tick(1'b1, 1'b1, 4'd11, 1'b0);
        idle(7);
        n_vec++;
        if (out_data1 !== 32'hCAFE_000B) begin
            n_bad++;
            $display("FAIL range_way11 got %h want cafe000b", out_data1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 16; w++) begin
                a_data[w*DW +: DW] = $urandom;
                b_data[w*DW +: DW] = $urandom;
            end
            tick(1'b1, (i % 2) == 0, 4'($urandom_range(0, 11)), 1'b0);
        end
        idle(7);
        n_vec++;
        if (out_src0 !== 1'b1 || out_src1 !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_last_src got %b/%b want 1/1", out_src0, out_src1);
        end
    endtask

    task automatic test_flush();
        a_data[2*DW +: DW] = 32'hF1F1_F1F1;
        tick(1'b1, 1'b1, 4'd2, 1'b0);
        idle(2);
        tick(1'b0, 1'b1, 4'd0, 1'b1);
        idle(7);
        n_vec++;
        if (out_data0 === 32'hF1F1_F1F1 || u_dut16.hold_a_q !== '0) begin
            n_bad++;
            $display("FAIL flush_drop got out=%h hold=%h want out!=f1f1f1f1 hold=0",
                     out_data0, u_dut16.hold_a_q);
        end
    endtask

    task automatic test_async_reset();
        a_data[4*DW +: DW] = 32'h4444_0004;
        b_data[6*DW +: DW] = 32'h6666_0006;
        tick(1'b1, 1'b1, 4'd4, 1'b0);
        idle(2);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({out_data0, out_valid0, out_src0, out_data1, out_valid1, out_src1} !== '0 ||
            u_dut16.hold_a_q !== '0) begin
            n_bad++;
            $display("FAIL async_reset got %h/%b/%b %h/%b/%b want all 0",
                     out_data0, out_valid0, out_src0, out_data1, out_valid1, out_src1);
        end
        @(negedge clk);
        reset = 1'b0;
        reset_sb();
        tick(1'b1, 1'b0, 4'd6, 1'b0);
        idle(7);
        n_vec++;
        if (out_data0 !== 32'h6666_0006 || out_src0 !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_beat got %h/%b want 66660006/1", out_data0, out_src0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_first_beat();
        test_b_turn();
        test_wrap_pang();
        test_out_of_range();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
